// File: rtl/robot_world_model.sv
// Grid robot on an 8x8 walled maze: tracks position, heading, move/bump counters
// and goal arrival. Wall sensing is combinational from the registered state.
module robot_world_model #(
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int START_DIR = 0,
    parameter int GOAL_X    = 7,
    parameter int GOAL_Y    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        front,
    input  logic        rotate,
    input  logic        map_we,
    input  logic [5:0]  map_addr,
    input  logic [3:0]  map_data,
    output logic        head,
    output logic        left,
    output logic [2:0]  pos_x,
    output logic [2:0]  pos_y,
    output logic [1:0]  dir,
    output logic [15:0] step_count,
    output logic [7:0]  bump_count,
    output logic        cmd_err,
    output logic        arrived
);

    localparam logic [2:0] START_X_L   = 3'(START_X);
    localparam logic [2:0] START_Y_L   = 3'(START_Y);
    localparam logic [1:0] START_DIR_L = 2'(START_DIR);
    localparam logic [2:0] GOAL_X_L    = 3'(GOAL_X);
    localparam logic [2:0] GOAL_Y_L    = 3'(GOAL_Y);
    localparam logic       START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Wall bits per cell, packed {W,S,E,N}; held in flops because reset must clear them.
    logic [3:0]  walls_reg [64];

    logic [2:0]  pos_x_reg, pos_x_next;
    logic [2:0]  pos_y_reg, pos_y_next;
    logic [1:0]  dir_reg, dir_next;
    logic [15:0] step_reg, step_next;
    logic [7:0]  bump_reg, bump_next;
    logic        err_reg, err_next;
    logic        arrived_reg, arrived_next;

    logic [3:0]  cell_walls;
    logic [3:0]  perim_walls;
    logic [3:0]  eff_walls;
    logic        cmd_move;
    logic        cmd_turn;
    logic        cmd_bad;
    logic        blocked;

    // Perimeter walls are forced regardless of the stored map.
    always_comb begin
        cell_walls  = walls_reg[{pos_y_reg, pos_x_reg}];
        perim_walls = {pos_x_reg == 3'd0, pos_y_reg == 3'd0,
                       pos_x_reg == 3'd7, pos_y_reg == 3'd7};
        eff_walls   = cell_walls | perim_walls;
        head        = eff_walls[dir_reg];
        left        = eff_walls[dir_reg + 2'd3];
    end

    always_comb begin
        cmd_move = run & front & ~rotate;
        cmd_turn = run & rotate & ~front;
        cmd_bad  = run & front & rotate;
        blocked  = head;
    end

    always_comb begin
        pos_x_next   = pos_x_reg;
        pos_y_next   = pos_y_reg;
        dir_next     = dir_reg;
        step_next    = step_reg;
        bump_next    = bump_reg;
        err_next     = cmd_bad;
        arrived_next = arrived_reg;

        if (cmd_turn) begin
            dir_next = dir_reg + 2'd1;
        end else if (cmd_move && blocked) begin
            if (bump_reg != 8'hFF) begin
                bump_next = bump_reg + 8'd1;
            end
        end else if (cmd_move) begin
            case (dir_reg)
                DIR_N:   pos_y_next = pos_y_reg + 3'd1;
                DIR_E:   pos_x_next = pos_x_reg + 3'd1;
                DIR_S:   pos_y_next = pos_y_reg - 3'd1;
                DIR_W:   pos_x_next = pos_x_reg - 3'd1;
                default: ;
            endcase
            if (step_reg != 16'hFFFF) begin
                step_next = step_reg + 16'd1;
            end
        end

        if (pos_x_next == GOAL_X_L && pos_y_next == GOAL_Y_L) begin
            arrived_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_reg   <= START_X_L;
            pos_y_reg   <= START_Y_L;
            dir_reg     <= START_DIR_L;
            step_reg    <= 16'd0;
            bump_reg    <= 8'd0;
            err_reg     <= 1'b0;
            arrived_reg <= START_AT_GOAL;
        end else begin
            pos_x_reg   <= pos_x_next;
            pos_y_reg   <= pos_y_next;
            dir_reg     <= dir_next;
            step_reg    <= step_next;
            bump_reg    <= bump_next;
            err_reg     <= err_next;
            arrived_reg <= arrived_next;
        end
    end

    // Map writes ignore run; a move in the same cycle already saw the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                walls_reg[i] <= 4'd0;
            end
        end else if (map_we) begin
            walls_reg[map_addr] <= map_data;
        end
    end

    assign pos_x      = pos_x_reg;
    assign pos_y      = pos_y_reg;
    assign dir        = dir_reg;
    assign step_count = step_reg;
    assign bump_count = bump_reg;
    assign cmd_err    = err_reg;
    assign arrived    = arrived_reg;

endmodule

// File: doc/robot_world_model.md
ROBOT_WORLD_MODEL -- requirements
Module: robot_world_model

Interface
REQ-001 Parameter START_X, default 0: reset column of robot, 0..7.
REQ-002 Parameter START_Y, default 0: reset row of robot, 0..7.
REQ-003 Parameter START_DIR, default 0: reset heading, 0=N 1=E 2=S 3=W.
REQ-004 Parameter GOAL_X, default 7: goal cell column.
REQ-005 Parameter GOAL_Y, default 7: goal cell row.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 run  input  1  1 = commands applied; 0 = robot frozen.
REQ-009 front  input  1  robot command: advance one cell.
REQ-010 rotate  input  1  robot command: turn 90 degrees clockwise.
REQ-011 map_we  input  1  maze write strobe.
REQ-012 map_addr  input  6  cell index {y[2:0],x[2:0]}.
REQ-013 map_data  input  4  cell walls {W,S,E,N}, 1 = wall.
REQ-014 head  output  1  wall directly ahead of robot.
REQ-015 left  output  1  wall on robot's left side.
REQ-016 pos_x  output  3  current column.
REQ-017 pos_y  output  3  current row.
REQ-018 dir  output  2  current heading.
REQ-019 step_count  output  16  successful moves, saturating.
REQ-020 bump_count  output  8  blocked moves, saturating.
REQ-021 cmd_err  output  1  one-cycle pulse on illegal command.
REQ-022 arrived  output  1  sticky flag, robot has reached goal cell.

Function
REQ-023 Maze SHALL be 8x8 cells, 4 wall bits per cell, y increasing northward, x increasing eastward.
REQ-024 Perimeter SHALL always be walled: N at y=7, S at y=0, E at x=7, W at x=0, regardless of stored bits.
REQ-025 Effective wall(d) of current cell SHALL = stored bit d OR perimeter wall d.
REQ-026 head SHALL = effective wall(dir); left SHALL = effective wall((dir+3) mod 4); both combinational from registered pos/dir and current map contents.
REQ-027 Commands SHALL be sampled at rising clk only when run=1; run=0 holds pos, dir, counters.
REQ-028 {front,rotate}=00: no change.
REQ-029 {front,rotate}=01: dir <= (dir+1) mod 4 next edge; pos unchanged; wraps 3->0.
REQ-030 {front,rotate}=10 with effective wall(dir)=0: move one cell (N:y+1, E:x+1, S:y-1, W:x-1), step_count +1.
REQ-031 {front,rotate}=10 with effective wall(dir)=1: pos unchanged, bump_count +1.
REQ-032 {front,rotate}=11: illegal; pos/dir/counters unchanged; cmd_err=1 for following cycle only.
REQ-033 Counters SHALL saturate at 16'hFFFF and 8'hFF, never wrap.
REQ-034 map_we=1 SHALL write map_data to map_addr at rising edge, independent of run.
REQ-035 Map write and move in same cycle: move SHALL use pre-write map contents.
REQ-036 arrived SHALL set on the edge where pos becomes (GOAL_X,GOAL_Y), or immediately after reset if START equals GOAL, and stay 1 until reset.
REQ-037 Robot SHALL continue accepting commands after arrived=1.
REQ-038 Latency: command at edge N reflected in pos/dir/head/left after edge N; no pipeline.

Reset
REQ-039 rst_n=0 SHALL immediately set pos=(START_X,START_Y), dir=START_DIR, step_count=0, bump_count=0, cmd_err=0, arrived=(START==GOAL).
REQ-040 rst_n=0 SHALL clear all stored interior wall bits to 0; perimeter walls remain per REQ-024.
REQ-041 Reset asserted mid-command SHALL discard that command; first command sampled at first rising edge after rst_n deasserts.

Verification
REQ-042 Reset, empty map, defaults -> pos=(0,0), dir=0, head=0, left=1 (west perimeter), counters 0, arrived=0.
REQ-043 From reset, 7 cycles front=1 -> pos_y=7, step_count=7, head=1; 8th front -> pos unchanged, bump_count=1.
REQ-044 Four cycles rotate=1 -> dir 1,2,3,0 in turn; at dir=1 (E) at (0,0): head=0, left=0.
REQ-045 Write map_addr=6'd0, map_data=4'b0001, then front=1 -> bump_count=1, pos=(0,0); simultaneous write and front in same cycle -> move executes using old map.
REQ-046 front=rotate=1 one cycle -> cmd_err=1 exactly one cycle, pos/dir/counters unchanged; run=0 with front=1 -> nothing changes.
REQ-047 Drive path to (7,7) -> arrived=1 on arrival edge, stays 1 after moving away; assert rst_n=0 mid-run -> all outputs to reset values asynchronously.
